// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state encoding and memCtrl width codes for the load/store sequencer
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsuState_e;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

endpackage

// File: rtl/lsu_sequencer_if.sv
// rtl/lsu_sequencer_if.sv - request/grant/response data-memory port
interface lsu_sequencer_if #(
  parameter int XLEN = 32
);

  logic            dReq;
  logic            dWe;
  logic [XLEN-1:0] dAddr;
  logic [3:0]      dBe;
  logic [XLEN-1:0] dWdata;
  logic            dGnt;
  logic            dRvalid;
  logic [XLEN-1:0] dRdata;
  logic            dErr;

  modport master (
    output dReq, dWe, dAddr, dBe, dWdata,
    input  dGnt, dRvalid, dRdata, dErr
  );

  modport slave (
    input  dReq, dWe, dAddr, dBe, dWdata,
    output dGnt, dRvalid, dRdata, dErr
  );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - access decode on the live request, lane formatting on the latched access
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            memRD,
  input  logic            memWR,
  input  logic [2:0]      reqCtrl,
  input  logic [1:0]      reqAddrLo,
  input  logic [2:0]      ctrl,
  input  logic [1:0]      addrLo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] busRdata,
  output logic            illegal,
  output logic            misaligned,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdataFmt,
  output logic [XLEN-1:0] loadData
);

  logic            loadOk;
  logic            storeOk;
  logic [XLEN-1:0] shifted;

  always_comb begin
    loadOk  = (reqCtrl == MEM_B) || (reqCtrl == MEM_H) || (reqCtrl == MEM_W) ||
              (reqCtrl == MEM_BU) || (reqCtrl == MEM_HU);
    storeOk = (reqCtrl == MEM_B) || (reqCtrl == MEM_H) || (reqCtrl == MEM_W);
    illegal = (memRD && memWR) || (memRD && !loadOk) || (memWR && !storeOk);
    case (reqCtrl[1:0])
      2'b01:   misaligned = reqAddrLo[0];
      2'b10:   misaligned = (reqAddrLo != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  // Store lanes are replicated so the memory picks the right bytes with dBe alone.
  always_comb begin
    be       = 4'b1111;
    wdataFmt = wdata;
    case (ctrl[1:0])
      2'b00: begin
        be       = 4'b0001 << addrLo;
        wdataFmt = {4{wdata[7:0]}};
      end
      2'b01: begin
        be       = 4'b0011 << {addrLo[1], 1'b0};
        wdataFmt = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = busRdata >> {addrLo, 3'b000};
    case (ctrl)
      MEM_B:   loadData = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      MEM_H:   loadData = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      MEM_BU:  loadData = {{(XLEN-8){1'b0}}, shifted[7:0]};
      MEM_HU:  loadData = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: loadData = busRdata;
    endcase
  end

endmodule

// File: rtl/lsu_sequencer.sv
// rtl/lsu_sequencer.sv - latches one load/store, runs the bus handshake and stalls the pipeline
module lsu_sequencer
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            memRD,
  input  logic            memWR,
  input  logic [2:0]      memCtrl,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic            flush,
  output logic [XLEN-1:0] rdata,
  output logic            lsuBusy,
  output logic            lsuDone,
  output logic            misalign,
  output logic            fault,
  lsu_sequencer_if.master dmem
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsuState_e       state, stateNext;
  logic [CW-1:0]   cnt, cntNext;
  logic            kill, killNext, killEff;
  logic [XLEN-1:0] addrLat, wdataLat, rdataNext;
  logic [2:0]      ctrlLat;
  logic            weLat;
  logic            latch, misalignNext, faultNext, request;
  logic            illegal, misaligned;
  logic [3:0]      be;
  logic [XLEN-1:0] wdataFmt, loadData;

  lsu_align #(.XLEN(XLEN)) uAlign (
    .memRD      (memRD),
    .memWR      (memWR),
    .reqCtrl    (memCtrl),
    .reqAddrLo  (addr[1:0]),
    .ctrl       (ctrlLat),
    .addrLo     (addrLat[1:0]),
    .wdata      (wdataLat),
    .busRdata   (dmem.dRdata),
    .illegal    (illegal),
    .misaligned (misaligned),
    .be         (be),
    .wdataFmt   (wdataFmt),
    .loadData   (loadData)
  );

  assign request = (memRD | memWR) & ~flush;

  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    killNext     = kill;
    killEff      = kill | flush;
    rdataNext    = rdata;
    latch        = 1'b0;
    misalignNext = 1'b0;
    faultNext    = 1'b0;
    lsuBusy      = 1'b0;
    lsuDone      = 1'b0;
    dmem.dReq    = 1'b0;
    dmem.dWe     = 1'b0;
    dmem.dAddr   = '0;
    dmem.dBe     = '0;
    dmem.dWdata  = '0;
    case (state)
      IDLE: begin
        if (request) begin
          if (illegal) begin
            faultNext = 1'b1;
          end else if (misaligned) begin
            misalignNext = 1'b1;
          end else begin
            latch     = 1'b1;
            lsuBusy   = 1'b1;
            stateNext = REQ;
          end
        end
      end
      REQ: begin
        lsuBusy     = 1'b1;
        dmem.dReq   = 1'b1;
        dmem.dWe    = weLat;
        dmem.dAddr  = {addrLat[XLEN-1:2], 2'b00};
        dmem.dBe    = be;
        dmem.dWdata = wdataFmt;
        // A flush coinciding with grant still owes the bus a response, so drain it.
        if (dmem.dGnt) begin
          stateNext = WAIT;
          cntNext   = '0;
          killNext  = flush;
        end else if (flush) begin
          stateNext = IDLE;
        end
      end
      WAIT: begin
        lsuBusy  = 1'b1;
        killNext = killEff;
        if (dmem.dRvalid) begin
          stateNext = IDLE;
          killNext  = 1'b0;
          if (dmem.dErr || killEff) begin
            faultNext = dmem.dErr & ~killEff;
          end else begin
            stateNext = DONE;
            if (!weLat) rdataNext = loadData;
          end
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          stateNext = IDLE;
          faultNext = ~killEff;
          killNext  = 1'b0;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      DONE: begin
        lsuDone   = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      kill     <= 1'b0;
      rdata    <= '0;
      misalign <= 1'b0;
      fault    <= 1'b0;
      addrLat  <= '0;
      wdataLat <= '0;
      ctrlLat  <= '0;
      weLat    <= 1'b0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      kill     <= killNext;
      rdata    <= rdataNext;
      misalign <= misalignNext;
      fault    <= faultNext;
      if (latch) begin
        addrLat  <= addr;
        wdataLat <= wdata;
        ctrlLat  <= memCtrl;
        weLat    <= memWR;
      end
    end
  end

endmodule

// File: doc/lsu_sequencer.md
Name: lsu_sequencer

Overview:
- Multi-cycle load/store sequencer between the decode controller's memory controls (memRD, memWR, memCtrl) and a request/grant/response data-memory port.
- Latches one access, drives the bus handshake and stalls the pipeline while the access is in flight.
- Formats store byte-enables/data, aligns and extends load data, and flags misaligned, illegal, errored or timed-out accesses.

Parameters:
XLEN, 32, data/address width (only 32 supported)
TIMEOUT, 64, max cycles in WAIT before fault (must be >= 2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
memRD  in  1  load request from controller
memWR  in  1  store request from controller
memCtrl  in  3  funct3 width code (000 B, 001 H, 010 W, 100 BU, 101 HU)
addr  in  XLEN  effective address
wdata  in  XLEN  store data (rs2)
flush  in  1  pipeline flush; kill current access
rdata  out  XLEN  aligned, extended load result; valid with lsuDone
lsuBusy  out  1  pipeline stall
lsuDone  out  1  one-cycle completion pulse
misalign  out  1  one-cycle misaligned-access pulse
fault  out  1  one-cycle illegal/error/timeout pulse
dReq  out  1  bus request
dWe  out  1  bus write enable
dAddr  out  XLEN  word address (bits [1:0] = 0)
dBe  out  4  byte enables
dWdata  out  XLEN  lane-replicated store data
dGnt  in  1  bus grant
dRvalid  in  1  bus response valid
dRdata  in  XLEN  bus read data
dErr  in  1  bus error, qualified by dRvalid

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, all outputs 0, timeout counter 0, kill flag 0. A reset mid-access abandons it; no pulses are emitted.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, request = memRD|memWR, flush=0:
  - memRD&memWR both high, or an illegal code (loads 011/110/111; stores anything other than 000/001/010): fault=1 next cycle, stay IDLE.
  - Misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0): misalign=1 next cycle, stay IDLE, no bus activity.
  - Otherwise latch addr, memCtrl, wdata and direction, then go to REQ.
- lsuBusy = (IDLE & valid aligned request & ~flush) | REQ | WAIT. It is combinational and low in DONE, so the pipeline advances in the DONE cycle.
- REQ: dReq=1, with dWe/dAddr/dBe/dWdata stable until dGnt. On dGnt go to WAIT, where dReq=0. flush in REQ before grant returns to IDLE with no pulse.
- WAIT: responses are counted only here; a response is never accepted in the grant cycle.
  - On dRvalid: if dErr or the kill flag is set, fault=dErr&~kill; otherwise capture rdata.
  - The counter increments each WAIT cycle. At TIMEOUT it pulses fault and returns to IDLE.
  - flush in WAIT sets the kill flag; the response is drained, then the block returns to IDLE with no lsuDone.
- DONE: lsuDone=1 and rdata valid for exactly one cycle, then IDLE. A request present in the DONE cycle is ignored; the controller re-presents it.
- Minimum latency, accept edge to lsuDone: 3 cycles (grant in the first REQ cycle, rvalid in the first WAIT cycle).
- Store formatting:
  - dBe: B = 0001<<addr[1:0], H = 0011<<{addr[1],1'b0}, W = 1111.
  - dWdata: B = {4{wdata[7:0]}}, H = {2{wdata[15:0]}}, W = wdata.
- Load formatting: shift dRdata right by 8*addr[1:0]. B/H sign-extend; BU/HU zero-extend; W passes through.
- rdata holds its last value outside DONE. Stores return rdata unchanged.

Decomposition:
- Shared package lsu_pkg: state enum (IDLE, REQ, WAIT, DONE) and memCtrl localparams (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU).
- One combinational sub-module, lsu_align: store byte-enable/data formatting, load extraction/extension, misalign and illegal-code detection.
- The FSM, counter and kill flag live in lsu_sequencer.

Test Plan:
- LW addr=0x100, dGnt in the 1st REQ cycle, dRvalid next cycle with dRdata=0xDEADBEEF -> dAddr=0x100, dBe=1111; lsuDone 3 cycles after accept; rdata=0xDEADBEEF; lsuBusy high for exactly 3 cycles.
- LB/LBU addr=0x103, dRdata=0x80FF_0000 -> dBe=1000; LB rdata=0xFFFFFF80, LBU rdata=0x00000080. LHU addr=0x102 -> rdata=0x000080FF.
- SH addr=0x202, wdata=0x1234ABCD, dGnt delayed 4 cycles -> dReq, dBe=1100 and dWdata=0xABCDABCD held stable through all 4 cycles; lsuDone after dRvalid.
- LW addr=0x101 -> misalign pulse, dReq never asserted, lsuBusy low. memRD=1 with memCtrl=011 -> fault pulse, no bus activity.
- Grant given, then flush asserted in WAIT, dRvalid 2 cycles later -> no lsuDone, return to IDLE. Separately, TIMEOUT=8 with no dRvalid -> fault exactly 8 WAIT cycles after grant.
- rst_n=0 for one cycle while in WAIT -> next cycle all outputs 0, state IDLE; a late dRvalid is ignored.
